// File: rtl/sat_down_counter_if.sv
// Control/status bundle for sat_down_counter.
// master: the controller driving load/count/start/stop/ack.
// slave : the counter itself.
interface sat_down_counter_if #(
   parameter int WIDTH = 3
);
   logic             ld_cnt;
   logic             cnt;
   logic             start;
   logic             stop;
   logic             ack;
   logic [WIDTH-1:0] init0;
   logic             bo;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] parout;

   modport master (
      output ld_cnt, cnt, start, stop, ack, init0,
      input  bo, busy, done, parout
   );

   modport slave (
      input  ld_cnt, cnt, start, stop, ack, init0,
      output bo, busy, done, parout
   );
endinterface

// File: rtl/sat_down_counter.sv
// Loadable saturating down-counter with a run/done handshake.
// The counter only decrements and sticks at zero. An IDLE/RUN/DONE FSM
// runs a load-and-count-down sequence and holds done until ack or stop.
// Optional feature macro AUTO_RELOAD_EN: the terminal count edge in RUN
// reloads the start value (rl_val) and stays in RUN, pulsing done for one
// cycle. A zero start value still ends in DONE so no zero-period loop forms.
module sat_down_counter #(
   parameter int WIDTH = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   sat_down_counter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef AUTO_RELOAD_EN
   logic [WIDTH-1:0] rl_val_q, rl_val_d;
   logic             reload_pulse;
`endif

   // Next state, next count and next-state-decoded busy/done.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef AUTO_RELOAD_EN
      rl_val_d     = rl_val_q;
      reload_pulse = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            // start implies the load, so start+ld_cnt is a single load
            if (bus.start) begin
               cnt_d   = bus.init0;
`ifdef AUTO_RELOAD_EN
               rl_val_d = bus.init0;
`endif
               state_d = (bus.init0 == ZERO) ? S_DONE : S_RUN;
            end else if (bus.ld_cnt) begin
               cnt_d = bus.init0;
            end else if (bus.cnt && (cnt_q != ZERO)) begin
               cnt_d = cnt_q - ONE;
            end
         end
         S_RUN: begin
            if (bus.ld_cnt) begin
               cnt_d = bus.init0;
               if (bus.init0 == ZERO) state_d = S_DONE;
            end else if (bus.cnt && (cnt_q > ONE)) begin
               cnt_d = cnt_q - ONE;
            end else if (bus.cnt && (cnt_q == ONE)) begin
`ifdef AUTO_RELOAD_EN
               // an aborting stop takes the plain terminal decrement, not a reload
               if (!bus.stop && (rl_val_q != ZERO)) begin
                  cnt_d        = rl_val_q;
                  reload_pulse = 1'b1;
               end else begin
                  cnt_d   = ZERO;
                  state_d = S_DONE;
               end
`else
               cnt_d   = ZERO;
               state_d = S_DONE;
`endif
            end
            // stop overrides the state change but keeps the count update
            if (bus.stop) state_d = S_IDLE;
         end
         S_DONE: begin
            if (bus.ld_cnt) cnt_d = bus.init0;
            if (bus.ack || bus.stop) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN);
`ifdef AUTO_RELOAD_EN
      done_d = (state_d == S_DONE) || reload_pulse;
`else
      done_d = (state_d == S_DONE);
`endif
   end

   // State, count and status registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= ZERO;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef AUTO_RELOAD_EN
         rl_val_q <= ZERO;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef AUTO_RELOAD_EN
         rl_val_q <= rl_val_d;
`endif
      end
   end

   assign bus.parout = cnt_q;
   assign bus.bo     = (cnt_q == ZERO);
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_sat_down_counter.sv
// Directed bench for sat_down_counter: vector table plus hand sequences
// for async reset, long DONE hold and (with AUTO_RELOAD_EN) reload pulses.
module tb_sat_down_counter;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   sat_down_counter_if #(.WIDTH(3)) bus ();

   sat_down_counter #(.WIDTH(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ld;
      logic       cn;
      logic       st;
      logic       sp;
      logic       ak;
      logic [2:0] i0;
      logic [2:0] e_par;
      logic       e_bo;
      logic       e_busy;
      logic       e_done;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic ld, input logic cn, input logic st,
                              input logic sp, input logic ak, input logic [2:0] i0,
                              input logic [2:0] ep, input logic ebo,
                              input logic ebusy, input logic edone);
      vec_t r;
      r.ld = ld; r.cn = cn; r.st = st; r.sp = sp; r.ak = ak; r.i0 = i0;
      r.e_par = ep; r.e_bo = ebo; r.e_busy = ebusy; r.e_done = edone;
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int ep, input int ebo,
                          input int ebusy, input int edone);
      chk({tag, ".parout"}, int'(bus.parout), ep);
      chk({tag, ".bo"},     int'(bus.bo),     ebo);
      chk({tag, ".busy"},   int'(bus.busy),   ebusy);
      chk({tag, ".done"},   int'(bus.done),   edone);
   endtask

   task automatic drive(input logic ld, input logic cn, input logic st,
                        input logic sp, input logic ak, input logic [2:0] i0);
      bus.ld_cnt = ld;
      bus.cnt    = cn;
      bus.start  = st;
      bus.stop   = sp;
      bus.ack    = ak;
      bus.init0  = i0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 3'd0);
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 3'd0);
      #2;
      chk_all("reset", 0, 1, 0, 0);
      tick();
      chk_all("reset_hold", 0, 1, 0, 0);
      rst_n = 1'b1;

`ifndef AUTO_RELOAD_EN
      //        ld cn st sp ak init0  parout bo busy done
      // start 3, count to DONE, ack
      vecs.push_back(v(0, 0, 1, 0, 0, 3'd3, 3'd3, 0, 1, 0));
      vecs.push_back(v(0, 1, 0, 0, 0, 3'd0, 3'd2, 0, 1, 0));
      vecs.push_back(v(0, 1, 0, 0, 0, 3'd0, 3'd1, 0, 1, 0));
      vecs.push_back(v(0, 1, 0, 0, 0, 3'd0, 3'd0, 1, 0, 1));
      vecs.push_back(v(0, 0, 0, 0, 0, 3'd0, 3'd0, 1, 0, 1));
      vecs.push_back(v(0, 0, 0, 0, 1, 3'd0, 3'd0, 1, 0, 0));
      // saturation at zero in IDLE, then ld_cnt beats cnt
      vecs.push_back(v(0, 1, 0, 0, 0, 3'd0, 3'd0, 1, 0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0, 3'd0, 3'd0, 1, 0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0, 3'd0, 3'd0, 1, 0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0, 3'd0, 3'd0, 1, 0, 0));
      vecs.push_back(v(1, 1, 0, 0, 0, 3'd6, 3'd6, 0, 0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0, 3'd0, 3'd5, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 3'd0, 3'd5, 0, 0, 0));
      // start with zero goes straight to DONE; ack in RUN ignored
      vecs.push_back(v(0, 0, 1, 0, 0, 3'd0, 3'd0, 1, 0, 1));
      vecs.push_back(v(0, 0, 0, 0, 1, 3'd0, 3'd0, 1, 0, 0));
      vecs.push_back(v(0, 0, 1, 0, 0, 3'd4, 3'd4, 0, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 3'd0, 3'd4, 0, 1, 0));
      // stop+cnt at 4: IDLE with 3; stop in IDLE ignored
      vecs.push_back(v(0, 1, 0, 1, 0, 3'd0, 3'd3, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 0, 3'd0, 3'd3, 0, 0, 0));
      // start 1; start in RUN ignored; terminal edge; cnt in DONE no effect
      vecs.push_back(v(0, 0, 1, 0, 0, 3'd1, 3'd1, 0, 1, 0));
      vecs.push_back(v(0, 0, 1, 0, 0, 3'd5, 3'd1, 0, 1, 0));
      vecs.push_back(v(0, 1, 0, 0, 0, 3'd0, 3'd0, 1, 0, 1));
      vecs.push_back(v(0, 1, 0, 0, 0, 3'd0, 3'd0, 1, 0, 1));
      // ld_cnt in DONE loads but stays DONE; stop leaves DONE
      vecs.push_back(v(1, 0, 0, 0, 0, 3'd5, 3'd5, 0, 0, 1));
      vecs.push_back(v(0, 0, 0, 1, 0, 3'd0, 3'd5, 0, 0, 0));
      // reload in RUN; reload with zero ends in DONE
      vecs.push_back(v(0, 0, 1, 0, 0, 3'd2, 3'd2, 0, 1, 0));
      vecs.push_back(v(1, 0, 0, 0, 0, 3'd7, 3'd7, 0, 1, 0));
      vecs.push_back(v(1, 1, 0, 0, 0, 3'd0, 3'd0, 1, 0, 1));
      vecs.push_back(v(0, 0, 0, 0, 1, 3'd0, 3'd0, 1, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].ld, vecs[i].cn, vecs[i].st, vecs[i].sp, vecs[i].ak, vecs[i].i0);
         tick();
         chk_all($sformatf("vec%0d", i), int'(vecs[i].e_par), int'(vecs[i].e_bo),
                 int'(vecs[i].e_busy), int'(vecs[i].e_done));
      end

      // DONE held for 10 cycles without ack
      drive(0, 0, 1, 0, 0, 3'd1);
      tick();
      chk_all("hold_start", 1, 0, 1, 0);
      drive(0, 1, 0, 0, 0, 3'd0);
      tick();
      chk_all("hold_term", 0, 1, 0, 1);
      drive(0, 0, 0, 0, 0, 3'd0);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("hold%0d.done", k), int'(bus.done), 1);
         chk($sformatf("hold%0d.busy", k), int'(bus.busy), 0);
      end
      drive(0, 0, 0, 0, 1, 3'd0);
      tick();
      chk_all("hold_ack", 0, 1, 0, 0);
`else
      // auto-reload: 2,1,2,1 with a one-cycle done pulse after each terminal edge
      drive(0, 0, 1, 0, 0, 3'd2);
      tick();
      chk_all("ar_start", 2, 0, 1, 0);
      drive(0, 1, 0, 0, 0, 3'd0);
      tick();
      chk_all("ar_c1", 1, 0, 1, 0);
      tick();
      chk_all("ar_c2", 2, 0, 1, 1);
      tick();
      chk_all("ar_c3", 1, 0, 1, 0);
      tick();
      chk_all("ar_c4", 2, 0, 1, 1);
      drive(0, 0, 0, 1, 0, 3'd0);
      tick();
      chk_all("ar_stop", 2, 0, 0, 0);
      // zero start value still ends in DONE
      drive(0, 0, 1, 0, 0, 3'd0);
      tick();
      chk_all("ar_zero", 0, 1, 0, 1);
      drive(0, 0, 0, 0, 1, 3'd0);
      tick();
      chk_all("ar_ack", 0, 1, 0, 0);
`endif

      // asynchronous reset mid-RUN at parout=5
      drive(0, 0, 1, 0, 0, 3'd6);
      tick();
      drive(0, 1, 0, 0, 0, 3'd0);
      tick();
      chk_all("pre_rst", 5, 0, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst_run", 0, 1, 0, 0);
      tick();
      chk_all("async_rst_held", 0, 1, 0, 0);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 3'd0);

      // asynchronous reset mid-DONE
      drive(0, 0, 1, 0, 0, 3'd0);
      tick();
      chk_all("pre_rst_done", 0, 1, 0, 1);
      drive(0, 0, 0, 0, 0, 3'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst_done", 0, 1, 0, 0);
      do_reset();
      tick();
      chk_all("post_rst_idle", 0, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
